// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates the single register-file write port between the in-order pipeline
// writeback and results from multi-cycle units. Multi-cycle results are held in
// a 2-entry in-order FIFO. By default the pipeline has fixed priority. The FIFO
// head drains whenever the pipeline is not using the port.
//
// Requests to register 0 never occupy the write port. Such a pipeline request
// is accepted immediately. Such a FIFO head is popped immediately. we3 never
// asserts for address 0.
//
// The winner of cycle N is registered and appears on we3/write_addr/wd3 in
// cycle N+1. With no winner, we3 drops and write_addr/wd3 keep their values.
//
// Optional feature (macro WB_STARVE_GUARD_EN):
//   Adds a starvation counter. It counts the cycles in which a non-zero FIFO
//   head loses to the pipeline. Once the count reaches STARVE_LIMIT, the FIFO
//   head is forced through for one cycle. During that cycle p_ready is pulled
//   low for a non-zero pipeline request.
//
// Parameters:
//   ADDRESS_WIDTH - register address width
//   DATA_WIDTH    - write data width
//   STARVE_LIMIT  - lost cycles before the FIFO head is forced (guard only)
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   p_valid/p_addr/p_data     - pipeline writeback request
//   p_ready                   - pipeline request accepted this cycle
//   m_valid/m_addr/m_data     - multi-cycle result push
//   m_ready                   - FIFO can accept a push
//   we3/write_addr/wd3        - registered register-file write port
//   fifo_count                - FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_valid,
    input  logic [ADDRESS_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0]    p_data,
    output logic                     p_ready,
    input  logic                     m_valid,
    input  logic [ADDRESS_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_ready,
    output logic                     we3,
    output logic [ADDRESS_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]    wd3,
    output logic [1:0]               fifo_count
);

    localparam int DEPTH = 2;

    // FIFO storage. Contents are not reset; reset empties the FIFO through the
    // pointers and the count, so stale entries are never read.
    logic [ADDRESS_WIDTH-1:0] fifo_addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_mem [DEPTH];
    logic                     wr_ptr_reg;
    logic                     rd_ptr_reg;
    logic [1:0]               count_reg;
    logic [1:0]               count_next;

    logic                     we3_reg;
    logic [ADDRESS_WIDTH-1:0] write_addr_reg;
    logic [DATA_WIDTH-1:0]    wd3_reg;

    logic                     head_valid;
    logic                     head_zero;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     p_nonzero;
    logic                     force_fifo;
    logic                     push;
    logic                     pop;
    logic                     p_grant;
    logic                     fifo_grant;

    // The head is taken only from registered state. A push into an empty FIFO
    // therefore becomes grantable one cycle later.
    assign head_valid = (count_reg != 2'd0);
    assign head_addr  = fifo_addr_mem[rd_ptr_reg];
    assign head_data  = fifo_data_mem[rd_ptr_reg];
    assign head_zero  = (head_addr == '0);
    assign p_nonzero  = p_valid && (p_addr != '0);

    // m_ready looks only at the current count. A same-cycle pop does not
    // let a third entry in.
    assign m_ready    = !rst && (count_reg != 2'd2);
    assign push       = m_valid && m_ready;

    assign p_ready    = !rst && !(force_fifo && p_nonzero);
    assign p_grant    = p_nonzero && p_ready;
    assign fifo_grant = !rst && head_valid && !head_zero && !p_grant;
    // A zero-address head is dropped regardless of who owns the port.
    assign pop        = !rst && head_valid && (head_zero || fifo_grant);

`ifdef WB_STARVE_GUARD_EN
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_reg;

    assign force_fifo = (starve_cnt_reg >= STARVE_W'(STARVE_LIMIT));

    // Counts only cycles in which a real (non-zero) head lost to the pipeline.
    // A forced grant pops the head, so the same rule also clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (!head_valid || pop) begin
            starve_cnt_reg <= '0;
        end else if (!head_zero && p_grant) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
`else
    assign force_fifo = 1'b0;
`endif

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_addr_mem[gi] <= m_addr;
                    fifo_data_mem[gi] <= m_data;
                end
            end
        end
    endgenerate

    // Registered write port. Address and data hold when there is no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_reg        <= 1'b0;
            write_addr_reg <= '0;
            wd3_reg        <= '0;
        end else if (p_grant) begin
            we3_reg        <= 1'b1;
            write_addr_reg <= p_addr;
            wd3_reg        <= p_data;
        end else if (fifo_grant) begin
            we3_reg        <= 1'b1;
            write_addr_reg <= head_addr;
            wd3_reg        <= head_data;
        end else begin
            we3_reg        <= 1'b0;
        end
    end

    assign we3        = we3_reg;
    assign write_addr = write_addr_reg;
    assign wd3        = wd3_reg;
    assign fifo_count = count_reg;

endmodule
